// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request checks for the load/store unit.
package lsu_pkg;

  localparam logic [31:0] ADDR_LIMIT = 32'h0000_0400;
  localparam int          NUM_LANES  = 4;
  localparam int          LANE_W     = 8;
  localparam int          OFF_W      = $clog2(NUM_LANES);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RESP} state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Unsigned variants exist only for loads; any other code is illegal.
  function automatic logic req_err(input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr);
    logic bad_f3, misal;
    bad_f3 = 1'b0;
    misal  = 1'b0;
    case (f3)
      F3_B:  ;
      F3_H:  misal = addr[0];
      F3_W:  misal = |addr[1:0];
      F3_BU: bad_f3 = we;
      F3_HU: begin bad_f3 = we; misal = addr[0]; end
      default: bad_f3 = 1'b1;
    endcase
    return bad_f3 | misal | (addr >= ADDR_LIMIT);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response plus word-memory port of the load/store unit.
interface lsu_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [2:0]  REQ_FUNCT3;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic [31:0] MEM_A;
  logic        MEM_WE;
  logic [31:0] MEM_WD;
  logic [31:0] MEM_RD;

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA, MEM_RD,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, MEM_A, MEM_WE, MEM_WD
  );

  modport master (
    output REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA, MEM_RD,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, MEM_A, MEM_WE, MEM_WD
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension and store lane merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] off,
  input  logic [31:0]      word,
  input  logic [31:0]      wdata,
  output logic [31:0]      ldata,
  output logic [31:0]      sdata
);

  logic [1:0]                         size;
  logic [NUM_LANES-1:0]               be;
  logic [NUM_LANES-1:0][LANE_W-1:0]   src;
  logic [31:0]                        shifted;

  assign size = funct3[1:0];

  // Byte lanes of the memory word: a lane is replaced when the access covers it.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam logic [OFF_W-1:0] K = OFF_W'(k);
    assign be[k]  = (size == SZ_W) |
                    ((size == SZ_H) & (off[1] == K[1])) |
                    ((size == SZ_B) & (off == K));
    assign src[k] = (size == SZ_B) ? wdata[7:0] :
                    (size == SZ_H) ? wdata[LANE_W*(k%2) +: LANE_W] :
                                     wdata[LANE_W*k +: LANE_W];
    assign sdata[LANE_W*k +: LANE_W] = be[k] ? src[k] : word[LANE_W*k +: LANE_W];
  end

  assign shifted = word >> {off, 3'b000};

  always_comb begin
    ldata = '0;
    case (funct3)
      F3_B:    ldata = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ldata = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    ldata = word;
      F3_BU:   ldata = {24'd0, shifted[7:0]};
      F3_HU:   ldata = {16'd0, shifted[15:0]};
      default: ldata = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Sequential load/store unit: one access per request, sub-word stores done as
// read-modify-write against a 32-bit word memory with combinational read.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  lsu_if.slave bus
);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic        err_q, err_d;
  logic [31:0] word_q, word_d;
  logic [31:0] ldata, sdata;
  logic [31:0] word_addr;

  assign word_addr = {req_q.addr[31:2], 2'b00};

  lsu_align u_align (
    .funct3 (req_q.funct3),
    .off    (req_q.addr[OFF_W-1:0]),
    .word   (word_q),
    .wdata  (req_q.wdata),
    .ldata  (ldata),
    .sdata  (sdata)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      err_q   <= err_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    err_d         = err_q;
    word_d        = word_q;
    bus.REQ_READY = 1'b0;
    bus.RSP_VALID = 1'b0;
    bus.RSP_RDATA = '0;
    bus.RSP_ERR   = 1'b0;
    bus.MEM_A     = '0;
    bus.MEM_WE    = 1'b0;
    bus.MEM_WD    = '0;
    case (state_q)
      ST_IDLE: begin
        bus.REQ_READY = 1'b1;
        if (bus.REQ_VALID) begin
          req_d = '{we: bus.REQ_WE, funct3: bus.REQ_FUNCT3,
                    addr: bus.REQ_ADDR, wdata: bus.REQ_WDATA};
          err_d = req_err(bus.REQ_WE, bus.REQ_FUNCT3, bus.REQ_ADDR);
          if (err_d)
            state_d = ST_RESP;
          else if (bus.REQ_WE && bus.REQ_FUNCT3 == F3_W)
            state_d = ST_WR;
          else
            state_d = ST_RD;
        end
      end
      ST_RD: begin
        bus.MEM_A = word_addr;
        word_d    = bus.MEM_RD;
        state_d   = req_q.we ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        // Word stores take every lane from wdata, so the stale word is unused.
        bus.MEM_A  = word_addr;
        bus.MEM_WE = 1'b1;
        bus.MEM_WD = sdata;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        bus.RSP_VALID = 1'b1;
        bus.RSP_ERR   = err_q;
        bus.RSP_RDATA = (!req_q.we && !err_q) ? ldata : '0;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a per-cycle behavioural trace model.
module tb_load_store_unit;

  typedef struct {
    logic        rdy, rv, err, we;
    logic [31:0] rd, a, wd;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  lsu_if bus();
  load_store_unit dut (.CLK(CLK), .RST(RST), .bus(bus));

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  bit          seed     = 1'b1;
  bit          checking = 1'b0;
  int          n_chk = 0, n_fail = 0, cyc = 0, acc_cyc = 0, rsp_lat = 0;
  logic [31:0] last_rd, last_wd;
  logic        last_err, mem_touch;
  exp_t        exp_q[$];
  exp_t        cur;

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory model (memoria): combinational read, write at the clock edge.
  assign bus.MEM_RD = mem[bus.MEM_A[9:2]];
  always @(posedge CLK) begin
    if (seed) for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    else if (bus.MEM_WE) mem[bus.MEM_A[9:2]] <= bus.MEM_WD;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  function automatic exp_t idle_e();
    exp_t e;
    e = '{rdy: 1'b1, rv: 1'b0, err: 1'b0, we: 1'b0, rd: 32'd0, a: 32'd0, wd: 32'd0};
    return e;
  endfunction

  function automatic exp_t busy_e();
    exp_t e;
    e = idle_e();
    e.rdy = 1'b0;
    return e;
  endfunction

  function automatic logic bad(input logic we, input logic [2:0] f, input logic [31:0] a);
    if (a >= 32'h400) return 1'b1;
    case (f)
      3'd0:       return 1'b0;
      3'd1:       return a[0];
      3'd2:       return a[1:0] != 2'd0;
      3'd4:       return we;
      3'd5:       return we | a[0];
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ld_val(input logic [2:0] f, input logic [31:0] w, input logic [1:0] off);
    logic [31:0] s, b, h;
    s = w >> (8 * off);
    b = s & 32'hFF;
    h = s & 32'hFFFF;
    case (f)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] st_val(input logic [2:0] f, input logic [31:0] w,
                                         input logic [31:0] wd, input logic [1:0] off);
    logic [31:0] mask;
    int          sh;
    mask = (f == 3'd0) ? 32'hFF : (f == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    sh   = (f == 3'd2) ? 0 : 8 * off;
    return (w & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  // Per-cycle compare of every DUT output against the expected trace.
  initial forever begin
    @(negedge CLK);
    cyc++;
    if (checking && !RST) begin
      cur = idle_e();
      if (exp_q.size() != 0) cur = exp_q.pop_front();
      chk("req_ready", 32'(bus.REQ_READY), 32'(cur.rdy));
      chk("rsp_valid", 32'(bus.RSP_VALID), 32'(cur.rv));
      chk("rsp_err",   32'(bus.RSP_ERR),   32'(cur.err));
      chk("rsp_rdata", bus.RSP_RDATA,      cur.rd);
      chk("mem_we",    32'(bus.MEM_WE),    32'(cur.we));
      chk("mem_a",     bus.MEM_A,          cur.a);
      chk("mem_wd",    bus.MEM_WD,         cur.wd);
      if (bus.RSP_VALID) begin
        last_rd  = bus.RSP_RDATA;
        last_err = bus.RSP_ERR;
        rsp_lat  = cyc - acc_cyc;
      end
      if (bus.MEM_WE) last_wd = bus.MEM_WD;
      if (bus.MEM_WE || bus.MEM_A != 32'd0) mem_touch = 1'b1;
    end
  end

  task automatic drive(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
    bus.REQ_VALID  = 1'b1;
    bus.REQ_WE     = we;
    bus.REQ_FUNCT3 = f;
    bus.REQ_ADDR   = a;
    bus.REQ_WDATA  = wd;
  endtask

  // Push the expected busy-cycle trace for an accepted request; returns its length.
  task automatic expect_req(input logic we, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] wd, output int n);
    exp_t        e;
    logic [31:0] wa, w;
    wa = {a[31:2], 2'b00};
    w  = ref_mem[a[9:2]];
    n  = 0;
    e  = busy_e();
    if (bad(we, f, a)) begin
      e.rv = 1'b1; e.err = 1'b1; exp_q.push_back(e); n = 1;
    end else if (!we) begin
      e.a = wa; exp_q.push_back(e);
      e = busy_e(); e.rv = 1'b1; e.rd = ld_val(f, w, a[1:0]); exp_q.push_back(e);
      n = 2;
    end else begin
      if (f != 3'd2) begin e.a = wa; exp_q.push_back(e); e = busy_e(); n++; end
      e.we = 1'b1; e.a = wa; e.wd = st_val(f, w, wd, a[1:0]);
      exp_q.push_back(e);
      ref_mem[a[9:2]] = e.wd;
      e = busy_e(); e.rv = 1'b1; exp_q.push_back(e);
      n += 2;
    end
  endtask

  // Called at a clock edge; returns at the edge that leaves RESP.
  task automatic do_req(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
    int n;
    #1;
    drive(we, f, a, wd);
    @(posedge CLK);
    #1;
    acc_cyc = cyc;
    // Request fields change after acceptance; the transaction must not notice.
    bus.REQ_VALID  = 1'b0;
    bus.REQ_WE     = 1'($urandom);
    bus.REQ_FUNCT3 = 3'($urandom);
    bus.REQ_ADDR   = $urandom;
    bus.REQ_WDATA  = $urandom;
    last_rd   = 32'hDEAD_BEEF;
    last_wd   = 32'hDEAD_BEEF;
    last_err  = 1'bx;
    mem_touch = 1'b0;
    rsp_lat   = -1;
    expect_req(we, f, a, wd, n);
    repeat (n) @(posedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic        we;
    logic [2:0]  f;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    bus.REQ_VALID = 1'b0;
    RST = 1'b1;
    @(posedge CLK);
    #1 seed = 1'b0;

    // Reset holds across edges.
    repeat (3) begin
      @(negedge CLK);
      chk("rst_ready",  32'(bus.REQ_READY), 32'd1);
      chk("rst_rvalid", 32'(bus.RSP_VALID), 32'd0);
      chk("rst_we",     32'(bus.MEM_WE),    32'd0);
      chk("rst_a",      bus.MEM_A,          32'd0);
      chk("rst_wd",     bus.MEM_WD,         32'd0);
    end
    #2;
    RST = 1'b0;
    checking = 1'b1;
    @(posedge CLK);

    // Directed cases with literal expectations.
    do_req(1'b1, 3'b010, 32'h0, 32'hFF11_931F);
    chk("sw_wd",  last_wd, 32'hFF11_931F);
    chk("sw_rd",  last_rd, 32'h0);
    chk("sw_lat", rsp_lat, 2);
    do_req(1'b0, 3'b000, 32'h3, 32'h0);
    chk("lb3",    last_rd, 32'hFFFF_FFFF);
    chk("lb_lat", rsp_lat, 2);
    do_req(1'b0, 3'b100, 32'h1, 32'h0);
    chk("lbu1",   last_rd, 32'h0000_0093);
    do_req(1'b0, 3'b001, 32'h2, 32'h0);
    chk("lh2",    last_rd, 32'hFFFF_FF11);
    do_req(1'b0, 3'b101, 32'h0, 32'h0);
    chk("lhu0",   last_rd, 32'h0000_931F);
    do_req(1'b1, 3'b000, 32'h2, 32'h0000_0013);
    chk("sb_wd",  last_wd, 32'hFF13_931F);
    chk("sb_lat", rsp_lat, 3);
    do_req(1'b0, 3'b010, 32'h0, 32'h0);
    chk("lw0",    last_rd, 32'hFF13_931F);

    do_req(1'b0, 3'b010, 32'h2, 32'h0);
    chk("err_lw2",   32'(last_err), 32'd1);
    chk("err_lw2_m", 32'(mem_touch), 32'd0);
    chk("err_lat",   rsp_lat, 1);
    do_req(1'b1, 3'b001, 32'h1, 32'h1234);
    chk("err_sh1",   32'(last_err), 32'd1);
    chk("err_sh1_m", 32'(mem_touch), 32'd0);
    do_req(1'b1, 3'b000, 32'h400, 32'h55);
    chk("err_sb400",   32'(last_err), 32'd1);
    chk("err_sb400_m", 32'(mem_touch), 32'd0);
    do_req(1'b0, 3'b011, 32'h4, 32'h0);
    chk("err_f3",   32'(last_err), 32'd1);
    chk("err_f3_m", 32'(mem_touch), 32'd0);

    // Reset while in WR of an SB: write abandoned, no response.
    #1;
    drive(1'b1, 3'b000, 32'h8, 32'h0000_00A5);
    @(posedge CLK);
    #1;
    bus.REQ_VALID = 1'b0;
    acc_cyc = cyc;
    expect_req(1'b1, 3'b000, 32'h8, 32'h0000_00A5, n);
    ref_mem[2] = init_val(2);
    @(negedge CLK);
    @(negedge CLK);
    #2;
    chk("wr_we_pre", 32'(bus.MEM_WE), 32'd1);
    RST = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_we_drop", 32'(bus.MEM_WE), 32'd0);
    chk("rst_a_drop",  bus.MEM_A, 32'd0);
    chk("rst_ready",   32'(bus.REQ_READY), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    @(posedge CLK);
    do_req(1'b0, 3'b010, 32'h8, 32'h0);
    chk("lw8_old", last_rd, init_val(2));

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 9) == 0) f = 3'($urandom);
      else if (we) f = 3'($urandom_range(0, 2));
      else begin
        f = 3'($urandom_range(0, 4));
        if (f == 3'd3) f = 3'd5;
      end
      if ($urandom_range(0, 15) == 0) a = 32'h400 + 32'($urandom_range(0, 64)) * (($urandom_range(0, 1) == 1) ? 32'h100_0000 : 32'd1);
      else a = 32'($urandom_range(0, 32'h3FF));
      if ($urandom_range(0, 4) != 0) begin
        if (f[1:0] == 2'b01) a[0] = 1'b0;
        if (f[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      do_req(we, f, a, $urandom);
    end

    repeat (2) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential load/store unit between the RISC-V core's memory stage and the word-organised data memory (`memoria`).
- Accepts one byte, halfword or word access per request.
- Checks alignment and range.
- Extracts and sign- or zero-extends load data.
- Performs sub-word stores as read-modify-write, since the memory has only a 32-bit write port with synchronous write and combinational read.
- Returns one response pulse per request.

## Interface
- ADDR_LIMIT, 32'h0000_0400, first illegal byte address; accesses at or above it are errors.
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  unit idle; request accepted on REQ_VALID && REQ_READY at a CLK edge.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_FUNCT3  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- REQ_ADDR  in  32  byte address.
- REQ_WDATA  in  32  store data, right-aligned.
- RSP_VALID  out  1  one-cycle response pulse; no backpressure.
- RSP_RDATA  out  32  extended load data; 0 for stores and errors.
- RSP_ERR  out  1  misaligned, illegal funct3 or out-of-range; valid with RSP_VALID.
- MEM_A  out  32  word-aligned address to memory (low two bits always 0).
- MEM_WE  out  1  memory write enable.
- MEM_WD  out  32  memory write data.
- MEM_RD  in  32  memory read data, combinational from MEM_A.

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: REQ_READY=1. On accept, latch WE, funct3, address and wdata, and evaluate the error condition.
- Error condition, any of:
  - funct3 not listed above for the access type;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - addr ≥ ADDR_LIMIT.
- Transitions on accept:
  - error → RESP with error flag set;
  - load → RD;
  - SW → WR;
  - SB/SH → RD.
- RD: MEM_A={addr[31:2],2'b00}. At the closing edge, capture MEM_RD into the word register. Next state: RESP for loads, WR for stores.
- WR: MEM_WE=1, MEM_A as in RD.
  - MEM_WD=wdata for SW.
  - Otherwise MEM_WD is the captured word with the target lane replaced.
  - Next state: RESP.
- RESP: RSP_VALID=1. Next state: IDLE.
- Lane mapping is little-endian:
  - byte lane addr[1:0], bits [8k+7:8k];
  - halfword lane addr[1], bits [16h+15:16h].
- Load extraction:
  - LB/LH sign-extend from bit 7/15;
  - LBU/LHU zero-extend;
  - LW passes the word.
- Outputs outside their active state:
  - MEM_A=0 outside RD/WR;
  - MEM_WE=0 and MEM_WD=0 outside WR;
  - RSP_RDATA and RSP_ERR = 0 outside RESP.
- An error request never asserts MEM_WE and never drives MEM_A.

## Timing
- Reset values: state IDLE, REQ_READY=1; RSP_VALID, RSP_RDATA, RSP_ERR, MEM_A, MEM_WE, MEM_WD all 0; internal registers cleared.
- RSP_VALID latency, counted in cycles after the accepting edge (it is high in that cycle):
  - error: 1;
  - load: 2;
  - SW: 2;
  - SB/SH: 3.
- REQ_READY is low from the accepting edge until the edge that leaves RESP. A back-to-back request is accepted at the first edge after RESP, so RESP cycles never overlap.
- REQ_VALID while REQ_READY=0 is ignored; the requester holds it.
- MEM_WE is high for exactly one cycle per successful store. The memory writes at the edge that closes WR.
- Reset mid-operation: RST drops MEM_WE immediately and the transaction is abandoned with no RSP_VALID.
  - A write whose WR-closing edge coincides with RST assertion is undefined.
  - A write whose WR-closing edge follows RST assertion must not occur.
- Inputs REQ_* are sampled only at the accepting edge. Later changes do not affect the transaction.

## Structure
- Package `lsu_pkg`: funct3 constants, state encoding, lane-select helper widths.
- Sub-module `lsu_align`: purely combinational; given funct3, addr[1:0], word and wdata, it produces the extracted/extended load value and the merged store word.
- The FSM and registers live in `load_store_unit`.

## Test plan
- Reset: RST=1 → REQ_READY=1, RSP_VALID=0, MEM_WE=0, MEM_A=0; holds across CLK edges.
- SW, addr 0, data FF11931F:
  - MEM_WE is a single-cycle pulse in cycle 1 with MEM_A=0 and MEM_WD=FF11931F;
  - RSP_VALID in cycle 2 with RSP_ERR=0 and RSP_RDATA=0.
- Loads over memory word 0 = FF11931F:
  - LB addr 3 → FFFFFFFF;
  - LBU addr 1 → 00000093;
  - LH addr 2 → FFFFFF11;
  - LHU addr 0 → 0000931F;
  - each response in cycle 2.
- SB addr 2 data 00000013 over FF11931F:
  - MEM_WD=FF13931F in cycle 2, RSP_VALID in cycle 3;
  - a following LW addr 0 returns FF13931F.
- Errors, each giving RSP_ERR=1 and RSP_VALID in cycle 1 with MEM_WE and MEM_A never nonzero:
  - LW addr 2;
  - SH addr 1;
  - SB addr 00000400;
  - load funct3 011.
- RST asserted while in WR for SB addr 8:
  - MEM_WE falls asynchronously;
  - no RSP_VALID;
  - REQ_READY=1 after release;
  - LW addr 8 returns the old contents.
